mru_tracker: RTL

MRU_TRACKER -- requirements
Module: mru_tracker

---
 rtl/mru_tracker.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mru_tracker.sv
// mru_tracker: button-driven resident-set tracker with an MRU replacement policy.
// A divided tick samples the buttons. A channel held for HOLD_TICKS ticks makes an
// access. An access lights the channel's LED; when the set is full, the access first
// evicts the current MRU channel.
// Optional feature macro: MRU_RELEASE_EN. When it is defined, a resident channel held
// for 2*HOLD_TICKS ticks is released. When it is undefined, the hold counters saturate
// at HOLD_TICKS and no channel is ever released.
module mru_tracker #(
    parameter int N_CH       = 4,
    parameter int CAPACITY   = 3,
    parameter int TICK_DIV   = 50_000_000,
    parameter int HOLD_TICKS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           btn,
    output logic [N_CH-1:0]           led,
    output logic [$clog2(N_CH)-1:0]   mru_idx,
    output logic                      mru_valid,
    output logic [$clog2(N_CH+1)-1:0] occupancy,
    output logic                      evict,
    output logic                      tick
);

    localparam int IDX_W = $clog2(N_CH);
    localparam int OCC_W = $clog2(N_CH + 1);
    localparam int CNT_W = $clog2(TICK_DIV);
`ifdef MRU_RELEASE_EN
    localparam int HOLD_MAX = 2 * HOLD_TICKS;
`else
    localparam int HOLD_MAX = HOLD_TICKS;
`endif
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);

    logic [CNT_W-1:0]  r_tick_cnt;
    logic [HOLD_W-1:0] r_hold [N_CH];
    logic [N_CH-1:0]   r_fired;
    logic [N_CH-1:0]   r_pending;
    logic [N_CH-1:0]   r_led;
    logic [IDX_W-1:0]  r_mru_idx;
    logic              r_mru_valid;
    logic [OCC_W-1:0]  r_occupancy;
    logic              r_evict;

    logic              w_tick;
    logic [HOLD_W-1:0] w_hold_nxt [N_CH];
    logic [N_CH-1:0]   w_fired_nxt;
    logic [N_CH-1:0]   w_new_req;
    logic [N_CH-1:0]   w_release;
    logic [N_CH-1:0]   w_req_all;
    logic              w_grant_vld;
    logic [IDX_W-1:0]  w_grant_idx;
    logic [N_CH-1:0]   w_grant_oh;
    logic [N_CH-1:0]   w_pending_nxt;
    logic [N_CH-1:0]   w_led_rel;
    logic [N_CH-1:0]   w_mru_oh;
    logic [OCC_W-1:0]  w_occ_rel;
    logic [N_CH-1:0]   w_led_nxt;
    logic [IDX_W-1:0]  w_mru_idx_nxt;
    logic              w_mru_valid_nxt;
    logic              w_evict_nxt;
    logic [OCC_W-1:0]  w_occ_nxt;

    // Occupancy is defined as the number of lit LEDs, so it is always derived from a
    // vector rather than tracked incrementally.
    function automatic logic [OCC_W-1:0] f_popcount(input logic [N_CH-1:0] v);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt = cnt + OCC_W'(v[i]);
        end
        return cnt;
    endfunction

    assign w_tick = (r_tick_cnt == CNT_W'(TICK_DIV - 1));

    // Per-channel hold counting, request detection (once per press) and release detection
    always_comb begin
        w_new_req   = '0;
        w_release   = '0;
        w_fired_nxt = r_fired;
        for (int i = 0; i < N_CH; i++) begin
            w_hold_nxt[i] = r_hold[i];
            if (w_tick) begin
                if (btn[i]) begin
                    if (r_hold[i] != HOLD_W'(HOLD_MAX)) begin
                        w_hold_nxt[i] = r_hold[i] + 1'b1;
                    end
                    // The count reaches HOLD_TICKS on this tick; r_fired blocks repeats until re-armed
                    if ((r_hold[i] == HOLD_W'(HOLD_TICKS - 1)) && !r_fired[i]) begin
                        w_new_req[i]   = 1'b1;
                        w_fired_nxt[i] = 1'b1;
                    end
`ifdef MRU_RELEASE_EN
                    if ((r_hold[i] == HOLD_W'(2 * HOLD_TICKS - 1)) && r_led[i]) begin
                        w_release[i] = 1'b1;
                    end
`endif
                end else begin
                    w_hold_nxt[i]  = '0;
                    w_fired_nxt[i] = 1'b0;
                end
            end
        end
    end

    // Fixed-priority arbiter: serve the lowest-index request on each tick; the rest stay pending
    always_comb begin
        w_req_all   = r_pending | w_new_req;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_req_all[i]) begin
                w_grant_vld = w_tick;
                w_grant_idx = IDX_W'(i);
            end
        end
        w_grant_oh    = w_grant_vld ? (N_CH'(1) << w_grant_idx) : '0;
        w_pending_nxt = w_tick ? (w_req_all & ~w_grant_oh) : r_pending;
    end

    // Resident-set update: apply releases first, then the granted access (hit, fill or evict-MRU)
    always_comb begin
        w_led_rel       = r_led & ~w_release;
        w_mru_oh        = N_CH'(1) << r_mru_idx;
        w_occ_rel       = f_popcount(w_led_rel);
        w_led_nxt       = w_led_rel;
        w_mru_idx_nxt   = r_mru_idx;
        w_mru_valid_nxt = r_mru_valid && ((w_release & w_mru_oh) == '0);
        w_evict_nxt     = 1'b0;
        if (w_grant_vld) begin
            w_mru_idx_nxt   = w_grant_idx;
            w_mru_valid_nxt = 1'b1;
            if ((w_led_rel & w_grant_oh) == '0) begin
                if (w_occ_rel < OCC_W'(CAPACITY)) begin
                    w_led_nxt = w_led_rel | w_grant_oh;
                end else begin
                    w_led_nxt   = (w_led_rel & ~w_mru_oh) | w_grant_oh;
                    w_evict_nxt = 1'b1;
                end
            end
        end
        w_occ_nxt = f_popcount(w_led_nxt);
    end

    // Free-running tick divider, restarting from zero after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Hold counters, re-arm flags and pending requests
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                r_hold[i] <= '0;
            end
            r_fired   <= '0;
            r_pending <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_hold[i] <= w_hold_nxt[i];
            end
            r_fired   <= w_fired_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // Registered resident set, MRU pointer, occupancy and eviction pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led       <= '0;
            r_mru_idx   <= '0;
            r_mru_valid <= 1'b0;
            r_occupancy <= '0;
            r_evict     <= 1'b0;
        end else begin
            r_led       <= w_led_nxt;
            r_mru_idx   <= w_mru_idx_nxt;
            r_mru_valid <= w_mru_valid_nxt;
            r_occupancy <= w_occ_nxt;
            r_evict     <= w_evict_nxt;
        end
    end

    assign led       = r_led;
    assign mru_idx   = r_mru_idx;
    assign mru_valid = r_mru_valid;
    assign occupancy = r_occupancy;
    assign evict     = r_evict;
    assign tick      = w_tick;

endmodule
